uart_receiver: RTL

Serial 8N1 UART receiver: the receive-side counterpart of the board's existing UART transmitter. It synchronises the asynchronous `RxD` line into the `clk` domain and detects start bits. It samples each bit at its centre using a baud counter and presents each received byte on `data` with a one-cycle `data_valid` strobe. Frames with a bad stop bit are flagged on `framing_error`. The receiver sits beside the transmitter in the top level, and its outputs drive LEDs and debug pins.

---
 rtl/uart_receiver_if.sv | 25 ++
 rtl/uart_receiver.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_receiver_if.sv
// Receiver-side bundle: serial line in, received byte and status strobes out.
interface uart_receiver_if;
   logic       RxD;
   logic [7:0] data;
   logic       data_valid;
   logic       framing_error;
   logic       busy;

   // master drives the line and observes the results; slave is the receiver itself
   modport master (
      output RxD,
      input  data,
      input  data_valid,
      input  framing_error,
      input  busy
   );

   modport slave (
      input  RxD,
      output data,
      output data_valid,
      output framing_error,
      output busy
   );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchroniser, centre sampling from a baud counter,
// registered byte with one-cycle valid strobe and one-cycle framing-error strobe.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic           clk,
   input  logic           reset,
   uart_receiver_if.slave bus
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [2:0]      r_bit;
   logic [2:0]      w_bit_nxt;
   logic [7:0]      r_shift;
   logic [7:0]      w_shift_nxt;
   logic [7:0]      r_data;
   logic [7:0]      w_data_nxt;
   logic            r_vld;
   logic            w_vld_nxt;
   logic            r_ferr;
   logic            w_ferr_nxt;

   logic            r_rx_meta;
   logic            r_rx_s;
   logic            r_rx_prev;
   logic            w_fall;

   // Synchroniser plus one history flop; all idle-high so reset never fakes a start edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= bus.RxD;
         r_rx_s    <= r_rx_meta;
         r_rx_prev <= r_rx_s;
      end
   end

   assign w_fall = r_rx_prev & ~r_rx_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= 3'd0;
         r_shift <= 8'h00;
         r_data  <= 8'h00;
         r_vld   <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_data  <= w_data_nxt;
         r_vld   <= w_vld_nxt;
         r_ferr  <= w_ferr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CW'(1);
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_data_nxt  = r_data;
      w_vld_nxt   = 1'b0;
      w_ferr_nxt  = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (w_fall) begin
               w_state_nxt = S_START;
            end
         end

         S_START: begin
            // A start bit that is high again at its centre was only a glitch
            if (r_cnt == HALF_M1) begin
               w_cnt_nxt = '0;
               if (!r_rx_s) begin
                  w_state_nxt = S_DATA;
                  w_bit_nxt   = 3'd0;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end

         S_DATA: begin
            if (r_cnt == FULL_M1) begin
               w_cnt_nxt          = '0;
               w_shift_nxt[r_bit] = r_rx_s;
               if (r_bit == 3'd7) begin
                  w_state_nxt = S_STOP;
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end
         end

         S_STOP: begin
            if (r_cnt == FULL_M1) begin
               w_cnt_nxt = '0;
               if (r_rx_s) begin
                  w_data_nxt  = r_shift;
                  w_vld_nxt   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_ferr_nxt  = 1'b1;
                  w_state_nxt = S_WAIT_HIGH;
               end
            end
         end

         S_WAIT_HIGH: begin
            // Hold off until the line recovers so a break reports only once
            w_cnt_nxt = '0;
            if (r_rx_s) begin
               w_state_nxt = S_IDLE;
            end
         end

         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.data          = r_data;
   assign bus.data_valid    = r_vld;
   assign bus.framing_error = r_ferr;
   assign bus.busy          = (r_state != S_IDLE);

   a_strobe_exclusive : assert property (@(posedge clk) disable iff (reset) !(r_vld && r_ferr));

endmodule
